// File: rtl/ram_scan_engine.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_engine
// Brief    : Dual-port RAM with tick/step driven read-address scanner,
//            read-during-write bypass and hardware clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module ram_scan_engine #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              run,
  input  logic              step,
  input  logic              clr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_cptr;
  logic [CNT_W-1:0]    r_tick_cnt;
  logic                r_step_q;

  logic w_scan;
  logic w_tick;
  logic w_step_rise;
  logic w_adv;
  logic w_bypass;

  assign w_scan      = (r_state == SCAN);
  assign w_tick      = w_scan & run & (r_tick_cnt == C_TICK_LAST);
  assign w_step_rise = step & ~r_step_q;
  assign w_adv       = w_scan & (run ? w_tick : w_step_rise);
  assign w_bypass    = w_scan & we & (wr_addr == r_ptr);

  // Storage is deliberately not reset; a reset edge also suppresses the
  // sweep write so an aborted clear leaves the remaining words intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_cptr] <= '0;
      end else if (we) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= SCAN;
      r_ptr      <= '0;
      r_cptr     <= '0;
      r_tick_cnt <= '0;
      r_step_q   <= 1'b0;
      busy       <= 1'b0;
      rd_addr    <= '0;
      rd_data    <= '0;
    end else begin
      r_step_q <= step;
      rd_addr  <= r_ptr;
      rd_data  <= w_bypass ? wr_data : r_mem[r_ptr];

      case (r_state)
        SCAN: begin
          if (run) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
          end
          if (w_adv) begin
            r_ptr <= r_ptr + 1'b1;
          end
          if (clr) begin
            r_state <= CLEAR;
            r_cptr  <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          r_cptr <= r_cptr + 1'b1;
          if (r_cptr == {ADDR_W{1'b1}}) begin
            r_state    <= SCAN;
            r_ptr      <= '0;
            r_tick_cnt <= '0;
            busy       <= 1'b0;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_scan_engine
// Brief    : Self-checking bench for ram_scan_engine against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_scan_engine;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 5;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 32;

  logic              clk;
  logic              reset;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              run;
  logic              step;
  logic              clr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  int total = 0;
  int bad   = 0;

  ram_scan_engine #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .run    (run),
    .step   (step),
    .clr    (clr),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: words, scan position, cycles since last advance.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_ptr      = 0;
  int                m_since    = 0;
  bit                m_step_q   = 0;
  bit                m_clearing = 0;
  int                m_swept    = 0;
  int                m_rd_addr  = 0;
  logic [DATA_W-1:0] m_rd_data  = '0;
  bit                m_busy     = 0;

  task automatic model_edge();
    bit rise;
    if (!reset) begin
      m_ptr = 0; m_since = 0; m_step_q = 0; m_clearing = 0;
      m_rd_addr = 0; m_rd_data = '0; m_busy = 0;
      return;
    end
    rise = step && !m_step_q;
    m_step_q = step;
    m_rd_addr = m_ptr;
    if (!m_clearing && we && int'(wr_addr) == m_ptr) m_rd_data = wr_data;
    else m_rd_data = m_mem[m_ptr];
    if (m_clearing) begin
      m_mem[m_swept] = '0;
      m_swept++;
      if (m_swept == DEPTH) begin
        m_clearing = 0; m_busy = 0; m_ptr = 0; m_since = 0;
      end
    end else begin
      if (we) m_mem[wr_addr] = wr_data;
      if (run) begin
        m_since++;
        if (m_since == TICK_DIV) begin
          m_since = 0;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end else if (rise) begin
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      if (clr) begin
        m_clearing = 1; m_swept = 0; m_busy = 1;
      end
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; wr_addr = '0; wr_data = '0; clr = 0; step = 0;
  endtask

  task automatic test_reset();
    reset = 0; run = 0;
    idle_inputs();
    repeat (3) clk_cycle();
    total++;
    if (rd_addr !== '0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
    total++;
    if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%0d want=0", rd_data); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    reset = 1;
  endtask

  task automatic test_run_scan();
    int prev;
    bit saw_wrap;
    run = 0;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i % 16);
      clk_cycle();
    end
    we = 0;
    run = 1;
    prev = int'(rd_addr);
    saw_wrap = 0;
    for (int c = 0; c < DEPTH * TICK_DIV + 8; c++) begin
      clk_cycle();
      total++;
      if (int'(rd_addr) !== m_rd_addr || rd_data !== m_rd_data) begin
        bad++;
        $display("FAIL run_scan cyc=%0d got=%0d/%0h want=%0d/%0h", c, rd_addr, rd_data, m_rd_addr, m_rd_data);
      end
      total++;
      if (rd_data !== DATA_W'(int'(rd_addr) % 16)) begin
        bad++;
        $display("FAIL run_pair addr=%0d got=%0h want=%0h", rd_addr, rd_data, int'(rd_addr) % 16);
      end
      if (prev == DEPTH - 1 && int'(rd_addr) == 0) saw_wrap = 1;
      prev = int'(rd_addr);
    end
    total++;
    if (saw_wrap !== 1'b1) begin bad++; $display("FAIL run_wrap got=%0b want=1", saw_wrap); end
  endtask

  task automatic test_step();
    reset = 0; clk_cycle(); reset = 1;
    run = 0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 20; c++) begin
        step = (c < 10);
        clk_cycle();
        total++;
        if (int'(rd_addr) !== m_rd_addr || rd_data !== m_rd_data) begin
          bad++;
          $display("FAIL step_mode k=%0d c=%0d got=%0d/%0h want=%0d/%0h", k, c, rd_addr, rd_data, m_rd_addr, m_rd_data);
        end
      end
    end
    step = 0;
    repeat (12) clk_cycle();
    total++;
    if (rd_addr !== ADDR_W'(3)) begin bad++; $display("FAIL step_count got=%0d want=3", rd_addr); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp;
    run = 0;
    repeat (4) begin
      step = 1; clk_cycle();
      step = 0; clk_cycle();
    end
    clk_cycle();
    total++;
    if (rd_addr !== ADDR_W'(7)) begin bad++; $display("FAIL bypass_ptr got=%0d want=7", rd_addr); end
    we = 1; wr_addr = ADDR_W'(7); wr_data = 4'hA;
    clk_cycle();
    we = 0;
    total++;
    if (rd_data !== 4'hA) begin bad++; $display("FAIL bypass_data got=%0h want=a", rd_data); end
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wr_addr = ADDR_W'(i); wr_data = DATA_W'((14 - i) & 15);
      clk_cycle();
    end
    we = 0;
    reset = 0; clk_cycle(); reset = 1;
    run = 1;
    for (int c = 0; c < DEPTH * TICK_DIV + 4; c++) begin
      clk_cycle();
      exp = DATA_W'((14 - int'(rd_addr)) & 15);
      total++;
      if (rd_data !== exp || int'(rd_addr) !== m_rd_addr) begin
        bad++;
        $display("FAIL readback addr=%0d got=%0h want=%0h (model addr %0d)", rd_addr, rd_data, exp, m_rd_addr);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we      = 1'($urandom_range(0, 1));
      wr_addr = ADDR_W'($urandom);
      wr_data = DATA_W'($urandom);
      run     = ($urandom_range(0, 3) != 0);
      step    = 1'($urandom_range(0, 1));
      clr     = ($urandom_range(0, 59) == 0);
      clk_cycle();
      total++;
      if (int'(rd_addr) !== m_rd_addr || rd_data !== m_rd_data || busy !== m_busy) begin
        bad++;
        $display("FAIL random cyc=%0d got=%0d/%0h/%0b want=%0d/%0h/%0b",
                 c, rd_addr, rd_data, busy, m_rd_addr, m_rd_data, m_busy);
      end
    end
    idle_inputs();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      clk_cycle();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle got busy=%0b want=0 after %0d cycles", busy, n); end
  endtask

  task automatic fill_nonzero();
    run = 0;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i % 15 + 1);
      clk_cycle();
    end
    we = 0;
  endtask

  task automatic test_clear();
    int busy_cycles;
    wait_idle();
    fill_nonzero();
    clr = 1; clk_cycle(); clr = 0;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      we = 1; wr_addr = ADDR_W'($urandom); wr_data = 4'hF;
      clk_cycle();
    end
    we = 0;
    total++;
    if (busy_cycles != DEPTH) begin bad++; $display("FAIL clear_busy_len got=%0d want=%0d", busy_cycles, DEPTH); end
    clk_cycle();
    total++;
    if (rd_addr !== '0) begin bad++; $display("FAIL clear_ptr got=%0d want=0", rd_addr); end
    run = 1;
    for (int c = 0; c < DEPTH * TICK_DIV + 4; c++) begin
      clk_cycle();
      total++;
      if (rd_data !== '0 || int'(rd_addr) !== m_rd_addr) begin
        bad++;
        $display("FAIL clear_scan addr=%0d got=%0h want=0 (model addr %0d)", rd_addr, rd_data, m_rd_addr);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [DATA_W-1:0] exp;
    fill_nonzero();
    clr = 1; clk_cycle(); clr = 0;
    repeat (10) clk_cycle();
    reset = 0; clk_cycle(); reset = 1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
    total++;
    if (rd_addr !== '0) begin bad++; $display("FAIL abort_ptr got=%0d want=0", rd_addr); end
    run = 1;
    for (int c = 0; c < DEPTH * TICK_DIV + 4; c++) begin
      clk_cycle();
      exp = (int'(rd_addr) < 10) ? '0 : DATA_W'(int'(rd_addr) % 15 + 1);
      total++;
      if (rd_data !== exp || rd_data !== m_rd_data) begin
        bad++;
        $display("FAIL abort_scan addr=%0d got=%0h want=%0h model=%0h", rd_addr, rd_data, exp, m_rd_data);
      end
    end
  endtask

  task automatic test_we_clr();
    run = 0;
    we = 1; wr_addr = ADDR_W'(5); wr_data = 4'h3; clr = 1;
    clk_cycle();
    idle_inputs();
    clk_cycle();
    wait_idle();
    repeat (5) begin
      step = 1; clk_cycle();
      step = 0; clk_cycle();
    end
    clk_cycle();
    total++;
    if (rd_addr !== ADDR_W'(5)) begin bad++; $display("FAIL weclr_ptr got=%0d want=5", rd_addr); end
    total++;
    if (rd_data !== '0 || rd_data !== m_rd_data) begin
      bad++;
      $display("FAIL weclr_data got=%0h want=0 model=%0h", rd_data, m_rd_data);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_scan();
    test_step();
    test_bypass();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_we_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_scan_engine.md
Name: ram_scan_engine

Overview:
- Parametrised dual-port RAM with an automatic read-address scanner. It is the successor to the fixed 32x4 RAM, free-running counter and external clock divider arrangement.
- It integrates the following into one single-clock block:
  - a tick-enable rate generator, which replaces clocking the RAM from a divided clock;
  - run/step scan modes;
  - a read-during-write bypass;
  - a hardware clear sweep.
- Sits between the board switch/key logic and the HEX display decoders at top level.

Parameters:
- DATA_W, 4, RAM word width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
- TICK_DIV, 25000000, clk cycles per scan advance in run mode; must be >= 1. Benches use 4.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- reset  in  1  synchronous, active-low reset: reset==0 on a rising clk edge resets the block.
- we  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- run  in  1  1 = auto-advance on tick; 0 = manual step mode.
- step  in  1  level from a debounced key; each rising edge advances one address while run==0.
- clr  in  1  single-cycle request to zero the entire RAM.
- rd_addr  out  ADDR_W  address of the word currently presented on rd_data.
- rd_data  out  DATA_W  RAM contents at rd_addr.
- busy  out  1  high while a clear sweep is in progress.

Behaviour:
- Reset values:
  - ptr = 0, rd_addr = 0, rd_data = 0.
  - tick counter = 0, step edge register = 0.
  - busy = 0, state = SCAN.
- RAM contents are not reset.
- Storage: DEPTH x DATA_W array. One write port and one read port, both synchronous to clk.
- Tick generator:
  - Counter runs 0..TICK_DIV-1, counting only in state SCAN with run==1.
  - tick is asserted for exactly one cycle when the count equals TICK_DIV-1; the counter then wraps to 0.
  - The counter holds its value while run==0.
- Step edge detect: step_rise = step & ~step_q, where step_q is step registered. Holding step advances once only.
- Advance:
  - In SCAN, adv = run ? tick : step_rise. step is ignored while run==1.
  - adv causes ptr <= ptr+1, with ptr wrapping from DEPTH-1 to 0.
- Read path:
  - Every cycle, rd_addr <= ptr and rd_data <= mem[ptr].
  - Latency is 1 cycle from a ptr change to the matching rd_addr/rd_data pair. The two outputs always update together.
- Write path: in SCAN with we==1, mem[wr_addr] <= wr_data at the clk edge.
- Read-during-write bypass: if we==1 in SCAN and wr_addr==ptr in the same cycle, rd_data <= wr_data (new data), not the old contents.
- FSM states: SCAN, CLEAR.
  - SCAN -> CLEAR on clr==1. At this transition cptr <= 0 and busy <= 1 on the same edge.
  - In CLEAR, each cycle mem[cptr] <= 0 and cptr <= cptr+1.
  - The sweep lasts exactly DEPTH cycles, with busy high for those DEPTH cycles.
  - The cycle that writes cptr==DEPTH-1 transitions to SCAN and sets ptr <= 0, tick counter <= 0, busy <= 0.
- Behaviour in CLEAR:
  - we, step, run-ticks and clr are all ignored.
  - The read path keeps sampling mem[ptr]; the displayed value may change to 0 as the sweep passes.
- Simultaneous events in SCAN:
  - we and clr in the same cycle: the write is performed, then the clear starts, so the written word ends up 0.
  - adv and we to the new ptr: the write lands on the old-ptr cycle ordering. The next cycle's read returns the written word.
- Reset mid-clear aborts the sweep to SCAN with busy=0. RAM is left partially cleared.
- Width rules:
  - All address arithmetic is modulo DEPTH.
  - wr_data is not extended or truncated; it is exactly DATA_W bits.

Test Plan:
- Reset, run=1, TICK_DIV=4, RAM preloaded with mem[i]=i%16 → rd_addr increments every 4 cycles: 0, 1, …, 31, 0. rd_data equals rd_addr%16 one cycle after each ptr change. Wrap 31→0 is observed.
- run=0, hold step high for 10 cycles then low, repeat 3 times → rd_addr advances exactly 3 (0→3). Tick counter frozen; no advance from ticks.
- run=0, ptr=7, we=1, wr_addr=7, wr_data=0xA → next cycle rd_data=0xA (bypass). Writes to addresses 0..31 with data 14-i (mod 16), then a run-mode scan → reads back 14-i at each address.
- Pulse clr with RAM full of nonzero data → busy high for exactly 32 cycles and we ignored during them. Afterwards rd_addr returns to 0 and a full scan reads all 0.
- Assert reset=0 at cycle 10 of a clear → busy=0 next cycle, rd_addr=0. Addresses 0..9 read 0 and addresses 10..31 retain their old data.
- we=1 (wr_addr=5, data=0x3) and clr in the same cycle → after the sweep, mem[5]=0.
